// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 multiplexer built as a binary tree of 2:1 levels.
// Each tree level is followed by a register stage. The stage carries the
// partially reduced data, the select bits that are still needed, an
// out-of-range flag and a valid bit. All stages advance together: they
// shift whenever the output register is empty or being drained.
module mux_tree_pipe #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [$clog2(NUM_IN)-1:0] in_sel,
  input  logic [NUM_IN*WIDTH-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_err
);

  localparam int SEL_W      = $clog2(NUM_IN);
  localparam int PAD        = 2**SEL_W;
  // All stage data registers packed back to back: stage k holds PAD>>(k+1) entries.
  localparam int DATA_BITS  = WIDTH * (PAD - 1);
  // Stage k keeps SEL_W-k-1 select bits; the last stage keeps none.
  localparam int SEL_BITS   = (SEL_W * (SEL_W - 1)) / 2;
  localparam int SEL_BITS_S = (SEL_BITS > 0) ? SEL_BITS : 1;

  // Bit offset of stage k inside the packed data vector.
  function automatic int data_off(input int k);
    return WIDTH * (PAD - (PAD >> k));
  endfunction

  // Bit offset of stage k inside the packed select vector.
  function automatic int sel_off(input int k);
    return k * (SEL_W - 1) - (k * (k - 1)) / 2;
  endfunction

  logic                  w_adv;
  logic [PAD*WIDTH-1:0]  w_leaf;
  logic                  w_err_in;
  logic [DATA_BITS-1:0]  w_data_p;
  logic [SEL_BITS_S-1:0] w_sel_p;
  logic [SEL_W-1:0]      w_vld_p;
  logic [SEL_W-1:0]      w_err_p;

  // Global advance: the whole pipe shifts unless the output beat is blocked.
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  // Leaf vector: real channels in the low part, padded leaves read as zero.
  always_comb begin
    w_leaf = '0;
    w_leaf[NUM_IN*WIDTH-1:0] = in_data;
  end

  // A select that lands on a padded leaf is flagged; power-of-two trees have none.
  if (PAD == NUM_IN) begin : g_no_pad
    assign w_err_in = 1'b0;
  end else begin : g_pad
    localparam logic [SEL_W-1:0] NUM_IN_C = SEL_W'(NUM_IN);
    assign w_err_in = (in_sel >= NUM_IN_C);
  end

  if (SEL_BITS == 0) begin : g_no_sel
    assign w_sel_p = '0;
  end

  for (genvar k = 0; k < SEL_W; k++) begin : g_lvl
    localparam int NK = PAD >> (k + 1);
    localparam int SW = SEL_W - k;

    logic [2*NK*WIDTH-1:0] w_dsrc;
    logic [SW-1:0]         w_ssrc;
    logic                  w_vsrc;
    logic                  w_esrc;
    logic [NK*WIDTH-1:0]   w_pick;
    logic [NK*WIDTH-1:0]   r_data;
    logic                  r_vld;
    logic                  r_err;

    if (k == 0) begin : g_first
      assign w_dsrc = w_leaf;
      assign w_ssrc = in_sel;
      assign w_vsrc = in_valid;
      assign w_esrc = w_err_in;
    end else begin : g_next
      assign w_dsrc = w_data_p[data_off(k-1) +: 2*NK*WIDTH];
      assign w_ssrc = w_sel_p[sel_off(k-1) +: SW];
      assign w_vsrc = w_vld_p[k-1];
      assign w_esrc = w_err_p[k-1];
    end

    // Pair entries (2j, 2j+1); the lowest live select bit picks the odd one.
    for (genvar j = 0; j < NK; j++) begin : g_pair
      assign w_pick[j*WIDTH +: WIDTH] = w_ssrc[0] ? w_dsrc[(2*j+1)*WIDTH +: WIDTH]
                                                  : w_dsrc[(2*j)*WIDTH +: WIDTH];
    end

    // ---- stage k register: shift on advance, payload only for valid beats ----
    always_ff @(posedge clk) begin
      if (rst) begin
        r_vld  <= 1'b0;
        r_err  <= 1'b0;
        r_data <= '0;
      end else if (w_adv) begin
        r_vld <= w_vsrc;
        if (w_vsrc) begin
          r_data <= w_pick;
          r_err  <= w_esrc;
        end
      end
    end

    assign w_data_p[data_off(k) +: NK*WIDTH] = r_data;
    assign w_vld_p[k] = r_vld;
    assign w_err_p[k] = r_err;

    if (k < SEL_W - 1) begin : g_sel
      logic [SW-2:0] r_sel;

      // Carry the select bits that later levels still need alongside the beat.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_sel <= '0;
        end else if (w_adv && w_vsrc) begin
          r_sel <= w_ssrc[SW-1:1];
        end
      end

      assign w_sel_p[sel_off(k) +: SW-1] = r_sel;
    end
  end

  // Last stage drives the outputs with no logic in between.
  assign out_valid = w_vld_p[SEL_W-1];
  assign out_err   = w_err_p[SEL_W-1];
  assign out_data  = w_data_p[DATA_BITS-1 -: WIDTH];

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Bench for mux_tree_pipe: three instances (8x8, 5x8 with padding, 64x32)
// checked by table vectors, directed corner sequences and a random stream
// against a queue-based reference of the selected channel.
module tb_mux_tree_pipe;

  localparam int AW = 8;  localparam int AN = 8;  localparam int AS = 3;
  localparam int BW = 8;  localparam int BN = 5;  localparam int BS = 3;
  localparam int CW = 32; localparam int CN = 64; localparam int CS = 6;

  typedef struct { logic [31:0] data; logic err; int cyc; } beat_t;
  typedef struct { logic [5:0] sel; logic [7:0] exp_d; logic exp_e; } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err;
  logic [AS-1:0]    a_in_sel;
  logic [AN*AW-1:0] a_in_data;
  logic [AW-1:0]    a_out_data;

  logic             b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
  logic [BS-1:0]    b_in_sel;
  logic [BN*BW-1:0] b_in_data;
  logic [BW-1:0]    b_out_data;

  logic             c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_err;
  logic [CS-1:0]    c_in_sel;
  logic [CN*CW-1:0] c_in_data;
  logic [CW-1:0]    c_out_data;

  mux_tree_pipe #(.WIDTH(AW), .NUM_IN(AN)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_sel(a_in_sel), .in_data(a_in_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .out_err(a_out_err));

  mux_tree_pipe #(.WIDTH(BW), .NUM_IN(BN)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_sel(b_in_sel), .in_data(b_in_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_err(b_out_err));

  mux_tree_pipe #(.WIDTH(CW), .NUM_IN(CN)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_sel(c_in_sel), .in_data(c_in_data), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_data(c_out_data), .out_err(c_out_err));

  beat_t qa[$];
  beat_t qb[$];
  beat_t qc[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  int    c_acc   = 0;
  int    c_ret   = 0;
  int    stale   = 0;
  logic  lat_chk = 1'b0;
  logic [7:0] a_exp_d, b_exp_d;
  logic       a_exp_e, b_exp_e;
  vec_t  t1[8];
  vec_t  t2[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: retire first, then record a newly accepted beat.
  task automatic monitor();
    beat_t b;
    int    s;
    if (rst) begin
      qa.delete(); qb.delete(); qc.delete();
      return;
    end
    if (a_out_valid && a_out_ready) begin
      check("A beat expected", 64'(qa.size() != 0), 64'(1));
      if (qa.size() != 0) begin
        b = qa.pop_front();
        check("A data", 64'(a_out_data), 64'(b.data[7:0]));
        check("A err", 64'(a_out_err), 64'(b.err));
        if (lat_chk) check("A latency", 64'(cyc - b.cyc), 64'(AS));
      end
    end
    if (a_in_valid && a_in_ready) qa.push_back('{data: 32'(a_exp_d), err: a_exp_e, cyc: cyc});

    if (b_out_valid && b_out_ready) begin
      check("B beat expected", 64'(qb.size() != 0), 64'(1));
      if (qb.size() != 0) begin
        b = qb.pop_front();
        check("B data", 64'(b_out_data), 64'(b.data[7:0]));
        check("B err", 64'(b_out_err), 64'(b.err));
      end
    end
    if (b_in_valid && b_in_ready) qb.push_back('{data: 32'(b_exp_d), err: b_exp_e, cyc: cyc});

    if (c_out_valid && c_out_ready) begin
      check("C beat expected", 64'(qc.size() != 0), 64'(1));
      if (qc.size() != 0) begin
        b = qc.pop_front();
        c_ret++;
        check("C data", 64'(c_out_data), 64'(b.data));
        check("C err", 64'(c_out_err), 64'(b.err));
      end
    end
    if (c_in_valid && c_in_ready) begin
      s = int'(c_in_sel);
      qc.push_back('{data: c_in_data[s*CW +: CW], err: (s >= CN), cyc: cyc});
      c_acc++;
    end
  endtask

  // Inputs are driven just after a falling edge; checks run before the rising edge.
  task automatic tick();
    #1;
    monitor();
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_sel = '0; a_out_ready = 1'b1; a_exp_d = '0; a_exp_e = 1'b0;
    b_in_valid = 1'b0; b_in_sel = '0; b_out_ready = 1'b1; b_exp_d = '0; b_exp_e = 1'b0;
    c_in_valid = 1'b0; c_in_sel = '0; c_out_ready = 1'b1; c_in_data = '0;
    for (int i = 0; i < AN; i++) a_in_data[i*AW +: AW] = 8'(16 + i);
    for (int i = 0; i < BN; i++) b_in_data[i*BW +: BW] = 8'(16 + i);
    @(negedge clk);
    @(negedge clk);

    // Reset state
    rst = 1'b0;
    #1;
    check("RST A out_valid", 64'(a_out_valid), 64'(0));
    check("RST A out_data", 64'(a_out_data), 64'(0));
    check("RST A out_err", 64'(a_out_err), 64'(0));
    check("RST A in_ready", 64'(a_in_ready), 64'(1));
    check("RST B out_valid", 64'(b_out_valid), 64'(0));
    check("RST C out_valid", 64'(c_out_valid), 64'(0));
    tick();

    // Table: full 8:1 stream, latency checked on each beat
    for (int i = 0; i < 8; i++) t1[i] = '{sel: 6'(i), exp_d: 8'(16 + i), exp_e: 1'b0};
    lat_chk = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_in_valid = 1'b1;
      a_in_sel   = t1[i].sel[2:0];
      a_exp_d    = t1[i].exp_d;
      a_exp_e    = t1[i].exp_e;
      #1;
      check("T1 in_ready", 64'(a_in_ready), 64'(1));
      tick();
    end
    a_in_valid = 1'b0;
    for (int n = 0; n < 10 && qa.size() != 0; n++) begin #1; tick(); end
    check("T1 drain", 64'(qa.size()), 64'(0));
    lat_chk = 1'b0;

    // Table: 5 channels, padded leaves and out-of-range flag
    t2[0] = '{sel: 6'd0, exp_d: 8'h10, exp_e: 1'b0};
    t2[1] = '{sel: 6'd4, exp_d: 8'h14, exp_e: 1'b0};
    t2[2] = '{sel: 6'd5, exp_d: 8'h00, exp_e: 1'b1};
    t2[3] = '{sel: 6'd7, exp_d: 8'h00, exp_e: 1'b1};
    for (int i = 0; i < 4; i++) begin
      b_in_valid = 1'b1;
      b_in_sel   = t2[i].sel[2:0];
      b_exp_d    = t2[i].exp_d;
      b_exp_e    = t2[i].exp_e;
      #1;
      tick();
    end
    b_in_valid = 1'b0;
    for (int n = 0; n < 10 && qb.size() != 0; n++) begin #1; tick(); end
    check("T2 drain", 64'(qb.size()), 64'(0));

    // Backpressure: three beats, four stalled cycles, then release
    a_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1'b1; a_in_sel = 3'(i + 1); a_exp_d = 8'(17 + i); a_exp_e = 1'b0;
      #1;
      check("BP fill in_ready", 64'(a_in_ready), 64'(1));
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1'b1; a_in_sel = 3'd7; a_exp_d = 8'h17;
      #1;
      check("BP stall out_valid", 64'(a_out_valid), 64'(1));
      check("BP stall in_ready", 64'(a_in_ready), 64'(0));
      check("BP stall data", 64'(a_out_data), 64'(8'h11));
      tick();
    end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("BP release out_valid", 64'(a_out_valid), 64'(1));
      check("BP release data", 64'(a_out_data), 64'(8'(17 + i)));
      tick();
    end
    #1;
    check("BP no extra beat", 64'(a_out_valid), 64'(0));
    check("BP queue empty", 64'(qa.size()), 64'(0));
    tick();

    // Bubble pattern 1,0,1
    a_in_valid = 1'b1; a_in_sel = 3'd6; a_exp_d = 8'h16; #1; tick();
    a_in_valid = 1'b0; a_in_sel = 3'd5;                  #1; tick();
    a_in_valid = 1'b1; a_in_sel = 3'd2; a_exp_d = 8'h12; #1; tick();
    a_in_valid = 1'b0;
    #1;
    check("BUB valid0", 64'(a_out_valid), 64'(1));
    check("BUB data0", 64'(a_out_data), 64'(8'h16));
    tick();
    #1;
    check("BUB valid1", 64'(a_out_valid), 64'(0));
    tick();
    #1;
    check("BUB valid2", 64'(a_out_valid), 64'(1));
    check("BUB data2", 64'(a_out_data), 64'(8'h12));
    tick();

    // Reset with two beats in flight
    a_in_valid = 1'b1; a_in_sel = 3'd4; a_exp_d = 8'h14; #1; tick();
    a_in_sel = 3'd5; a_exp_d = 8'h15;                    #1; tick();
    a_in_valid = 1'b0; rst = 1'b1;                       #1; tick();
    rst = 1'b0;
    #1;
    check("MRST out_valid", 64'(a_out_valid), 64'(0));
    check("MRST out_data", 64'(a_out_data), 64'(0));
    check("MRST out_err", 64'(a_out_err), 64'(0));
    check("MRST in_ready", 64'(a_in_ready), 64'(1));
    tick();
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (a_out_valid) stale++;
      tick();
    end
    check("MRST no stale beat", 64'(stale), 64'(0));

    // Random 64x32 stream with random backpressure
    for (int n = 0; n < 6000 && c_acc < 1000; n++) begin
      c_in_valid  = ($urandom_range(0, 3) != 0);
      c_in_sel    = 6'($urandom_range(0, 63));
      for (int i = 0; i < CN; i++) c_in_data[i*CW +: CW] = $urandom();
      c_out_ready = ($urandom_range(0, 2) != 0);
      #1;
      tick();
    end
    c_in_valid = 1'b0; c_out_ready = 1'b1;
    check("RND accepted", 64'(c_acc), 64'(1000));
    for (int n = 0; n < 20 && qc.size() != 0; n++) begin #1; tick(); end
    check("RND drain", 64'(qc.size()), 64'(0));
    check("RND retired", 64'(c_ret), 64'(1000));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
